// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding and its width.
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : timer_pkg

// File: rtl/reg_rst_en.sv
// Multi-bit register with synchronous active-high reset and load enable;
// reset wins over enable.
module reg_rst_en #(
    parameter int              nbits   = 8,
    parameter logic [nbits-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [nbits-1:0] d_i,
    output logic [nbits-1:0] q_o
);

    logic [nbits-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : reg_rst_en

// File: rtl/countdown_timer.sv
// Programmable down-counter; its one-cycle done pulse enables the downstream
// register bank. Moore outputs decode directly from the state register.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [nbits-1:0] load_val,
    input  logic             en,
    output logic [nbits-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e             state_q;
    state_e             state_d;
    logic [STATE_W-1:0] state_raw_q;
    logic [nbits-1:0]   count_q;
    logic [nbits-1:0]   count_d;
    logic               count_we;

    // Decrement floored at zero; the FSM leaves COUNT on the 1->0 step, so
    // the floor only guards against an illegal encoding.
    function automatic logic [nbits-1:0] dec_floor(input logic [nbits-1:0] v);
        return (v == '0) ? '0 : v - nbits'(1);
    endfunction

    reg_rst_en #(
        .nbits   (STATE_W),
        .RST_VAL (STATE_W'(IDLE))
    ) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (state_d),
        .q_o  (state_raw_q)
    );

    assign state_q = state_e'(state_raw_q);

    reg_rst_en #(
        .nbits   (nbits),
        .RST_VAL ('0)
    ) u_count_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (count_we),
        .d_i  (count_d),
        .q_o  (count_q)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        count_we = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // load_val is only looked at when start is accepted
                if (start) begin
                    count_we = 1'b1;
                    count_d  = load_val;
                    state_d  = (load_val == '0) ? DONE : COUNT;
                end else if (state_q == DONE) begin
                    count_we = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end
            end
            COUNT: begin
                if (en) begin
                    count_we = 1'b1;
                    count_d  = dec_floor(count_q);
                    if (count_q <= nbits'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                count_we = 1'b1;
                count_d  = '0;
                state_d  = IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = (state_q == COUNT);
    assign done  = (state_q == DONE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer with an expectation queue checked
// one time unit after every rising edge.
module tb_countdown_timer;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] load_val = '0;
    logic          en = 1'b0;
    logic [NB-1:0] count;
    logic          busy;
    logic          done;

    countdown_timer #(.nbits(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          start;
        logic [NB-1:0] lv;
        logic          en;
        logic [NB-1:0] cnt;
        logic          busy;
        logic          done;
        string         tag;
    } vec_t;

    typedef struct {
        logic [NB-1:0] cnt;
        logic          busy;
        logic          done;
        string         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic r, input logic s, input logic [NB-1:0] lv,
                                input logic en_v, input logic [NB-1:0] c,
                                input logic b, input logic d, input string tag);
        vec_t v;
        v.rst = r; v.start = s; v.lv = lv; v.en = en_v;
        v.cnt = c; v.busy = b; v.done = d; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs and queue what must appear after the next edge.
    task automatic drive(input logic r, input logic s, input logic [NB-1:0] lv,
                         input logic en_v, input logic [NB-1:0] c,
                         input logic b, input logic d, input string tag);
        exp_t x;
        @(negedge clk);
        rst = r; start = s; load_val = lv; en = en_v;
        x.cnt = c; x.busy = b; x.done = d; x.tag = tag;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (count !== e.cnt || busy !== e.busy || done !== e.done) begin
                n_fail++;
                $display("FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         e.tag, count, busy, done, e.cnt, e.busy, e.done);
            end
            n_checks++;
            if ((busy & done) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_excl: got busy=%b done=%b, want not both high", e.tag, busy, done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset then idle; en and load_val must not matter while idle
        add(1, 0, 8'h00, 0, 0, 0, 0, "rst");
        add(0, 0, 8'h5a, 0, 0, 0, 0, "idle0");
        add(0, 0, 8'hff, 1, 0, 0, 0, "idle1");
        add(0, 0, 8'h00, 0, 0, 0, 0, "idle2");
        add(0, 0, 8'h33, 1, 0, 0, 0, "idle3");
        // basic count of 3
        add(0, 1, 8'd3, 1, 3, 1, 0, "basic_ld");
        add(0, 0, 8'd0, 1, 2, 1, 0, "basic_2");
        add(0, 0, 8'd0, 1, 1, 1, 0, "basic_1");
        add(0, 0, 8'd0, 1, 0, 0, 1, "basic_done");
        add(0, 0, 8'd0, 1, 0, 0, 0, "basic_idle");
        // enable stall, en pattern 1,0,0,1,1,1
        add(0, 1, 8'd4, 0, 4, 1, 0, "stall_ld");
        add(0, 0, 8'd0, 1, 3, 1, 0, "stall_e1");
        add(0, 0, 8'd0, 0, 3, 1, 0, "stall_e0a");
        add(0, 0, 8'd0, 0, 3, 1, 0, "stall_e0b");
        add(0, 0, 8'd0, 1, 2, 1, 0, "stall_e1b");
        add(0, 0, 8'd0, 1, 1, 1, 0, "stall_e1c");
        add(0, 0, 8'd0, 1, 0, 0, 1, "stall_done");
        add(0, 0, 8'd0, 0, 0, 0, 0, "stall_idle");
        // zero-length load
        add(0, 1, 8'd0, 0, 0, 0, 1, "zero_done");
        add(0, 0, 8'd7, 0, 0, 0, 0, "zero_idle");
        // start ignored mid-count, then back-to-back restart from DONE
        add(0, 1, 8'd5, 1, 5, 1, 0, "ign_ld");
        add(0, 1, 8'd9, 1, 4, 1, 0, "ign_4");
        add(0, 1, 8'd9, 1, 3, 1, 0, "ign_3");
        add(0, 1, 8'd9, 0, 3, 1, 0, "ign_hold");
        add(0, 0, 8'd9, 1, 2, 1, 0, "ign_2");
        add(0, 0, 8'd0, 1, 1, 1, 0, "ign_1");
        add(0, 0, 8'd0, 1, 0, 0, 1, "ign_done");
        add(0, 1, 8'd2, 1, 2, 1, 0, "b2b_ld");
        add(0, 0, 8'd0, 1, 1, 1, 0, "b2b_1");
        add(0, 0, 8'd0, 1, 0, 0, 1, "b2b_done");
        add(0, 1, 8'd0, 1, 0, 0, 1, "b2b_zero");
        add(0, 0, 8'd0, 1, 0, 0, 0, "b2b_idle");
        // mid-count reset at count=3, no done pulse afterwards
        add(0, 1, 8'd6, 1, 6, 1, 0, "mrst_ld");
        add(0, 0, 8'd0, 1, 5, 1, 0, "mrst_5");
        add(0, 0, 8'd0, 1, 4, 1, 0, "mrst_4");
        add(0, 0, 8'd0, 1, 3, 1, 0, "mrst_3");
        add(1, 0, 8'd0, 1, 0, 0, 0, "mrst_rst");
        add(0, 0, 8'd0, 1, 0, 0, 0, "mrst_q0");
        add(0, 0, 8'd0, 1, 0, 0, 0, "mrst_q1");
        add(0, 0, 8'd0, 1, 0, 0, 0, "mrst_q2");
        // reset overrides a start request
        add(1, 1, 8'd7, 1, 0, 0, 0, "rst_vs_start");
        add(0, 0, 8'd0, 0, 0, 0, 0, "rst_vs_idle");

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].lv, vecs[i].en,
                  vecs[i].cnt, vecs[i].busy, vecs[i].done, vecs[i].tag);
        end

        // maximum load: 255 enabled cycles to done, with one stall partway
        drive(0, 1, 8'd255, 1, 8'd255, 1, 0, "max_ld");
        for (int i = 1; i < 255; i++) begin
            drive(0, 0, 8'd0, 1, 8'(255 - i), 1, 0, "max_cnt");
            if (i == 100) drive(0, 0, 8'd0, 0, 8'(255 - i), 1, 0, "max_stall");
        end
        drive(0, 0, 8'd0, 1, 8'd0, 0, 1, "max_done");
        drive(0, 0, 8'd0, 1, 8'd0, 0, 0, "max_idle");
        drive(0, 0, 8'd0, 0, 8'd0, 0, 0, "max_idle2");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_countdown_timer
